// File: rtl/arith_decoder.sv
// Binary arithmetic decoder, fastqz/ZPAQ compatible (decompression side).
// Define ARITH_DEC_STATS_EN to add the BitCnt/ByteCnt statistics ports.
module arith_decoder #(
  parameter int IN_DW   = 8,
  parameter int Prob_DW = 32,
  parameter int P_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IN_DW-1:0]   DecIn,
  input  logic               InputValid,
  output logic               InputReady,
  input  logic [P_W-1:0]     p,
  input  logic               pValid,
  output logic               pReady,
  output logic               y,
  output logic               OutputValid,
  input  logic               OutputReady,
  output logic               InitFinish,
  output logic [Prob_DW-1:0] DecLow,
  output logic [Prob_DW-1:0] DecHigh,
  output logic [Prob_DW-1:0] DecMid,
  output logic [Prob_DW-1:0] DecX
`ifdef ARITH_DEC_STATS_EN
  ,
  output logic [31:0]        BitCnt,
  output logic [31:0]        ByteCnt
`endif
);

  typedef enum logic [2:0] {
    S_Idle, S_Init, S_WaitP, S_Mid, S_Bit, S_Out, S_Shift
  } state_e;

  localparam logic [Prob_DW-1:0] ONES = '1;
  localparam logic [Prob_DW-1:0] LO_MASK =
    {{(Prob_DW-P_W){1'b0}}, {P_W{1'b1}}};

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [Prob_DW-1:0] low_q, low_d;
  logic [Prob_DW-1:0] high_q, high_d;
  logic [Prob_DW-1:0] mid_q, mid_d;
  logic [Prob_DW-1:0] x_q, x_d;
  logic [P_W-1:0]     p_q, p_d;
  logic               y_q, y_d;
  logic               ov_q, ov_d;
  logic               init_q, init_d;

  logic               in_hs;
  logic [Prob_DW-1:0] r, prod_hi, prod_lo, mid_calc;
  logic [Prob_DW-1:0] high_sh, low_sh, x_sh;

  assign InputReady  = (state_q == S_Init) || (state_q == S_Shift);
  assign pReady      = (state_q == S_WaitP);
  assign in_hs       = InputValid && InputReady;
  assign y           = y_q;
  assign OutputValid = ov_q;
  assign InitFinish  = init_q;
  assign DecLow      = low_q;
  assign DecHigh     = high_q;
  assign DecMid      = mid_q;
  assign DecX        = x_q;

  // Split-product midpoint: products are truncated to the register width.
  always_comb begin
    r        = high_q - low_q;
    prod_hi  = (r >> P_W) * Prob_DW'(p_q);
    prod_lo  = (r & LO_MASK) * Prob_DW'(p_q);
    mid_calc = low_q + prod_hi + (prod_lo >> P_W);
    high_sh  = {high_q[Prob_DW-IN_DW-1:0], {IN_DW{1'b1}}};
    low_sh   = {low_q[Prob_DW-IN_DW-1:0], {IN_DW{1'b0}}};
    x_sh     = {x_q[Prob_DW-IN_DW-1:0], DecIn};
  end

  // Next-state and datapath updates for the decode sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    low_d   = low_q;
    high_d  = high_q;
    mid_d   = mid_q;
    x_d     = x_q;
    p_d     = p_q;
    y_d     = y_q;
    ov_d    = ov_q;
    init_d  = init_q;
    unique case (state_q)
      S_Idle: begin
        if (start) begin
          state_d = S_Init;
          cnt_d   = '0;
          low_d   = '0;
          high_d  = ONES;
          x_d     = '0;
          init_d  = 1'b0;
        end
      end
      S_Init: begin
        if (in_hs) begin
          x_d   = x_sh;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WaitP;
            init_d  = 1'b1;
          end
        end
      end
      S_WaitP: begin
        if (pValid) begin
          p_d     = p;
          state_d = S_Mid;
        end
      end
      S_Mid: begin
        mid_d   = mid_calc;
        state_d = S_Bit;
      end
      S_Bit: begin
        y_d = (x_q <= mid_q);
        if (x_q <= mid_q) high_d = mid_q;
        else              low_d  = mid_q + Prob_DW'(1);
        ov_d    = 1'b1;
        state_d = S_Out;
      end
      S_Out: begin
        if (OutputReady) begin
          ov_d = 1'b0;
          if (high_q[Prob_DW-1 -: IN_DW] == low_q[Prob_DW-1 -: IN_DW])
            state_d = S_Shift;
          else
            state_d = S_WaitP;
        end
      end
      S_Shift: begin
        if (in_hs) begin
          high_d = high_sh;
          low_d  = low_sh;
          x_d    = x_sh;
          if (high_sh[Prob_DW-1 -: IN_DW] != low_sh[Prob_DW-1 -: IN_DW])
            state_d = S_WaitP;
        end
      end
      default: state_d = S_Idle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_Idle;
      cnt_q   <= '0;
      low_q   <= '0;
      high_q  <= ONES;
      mid_q   <= '0;
      x_q     <= '0;
      p_q     <= '0;
      y_q     <= 1'b0;
      ov_q    <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      high_q  <= high_d;
      mid_q   <= mid_d;
      x_q     <= x_d;
      p_q     <= p_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
      init_q  <= init_d;
    end
  end

`ifdef ARITH_DEC_STATS_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;

  assign BitCnt  = bit_cnt_q;
  assign ByteCnt = byte_cnt_q;

  // Handshake counters, cleared when a new stream starts.
  always_comb begin
    bit_cnt_d  = bit_cnt_q + 32'(ov_q && OutputReady);
    byte_cnt_d = byte_cnt_q + 32'(in_hs);
    if (state_q == S_Idle && start) begin
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_arith_decoder.sv
// Scoreboard bench for arith_decoder: directed vectors plus an
// encoder-model round trip; stats ports checked when ARITH_DEC_STATS_EN.
module tb_arith_decoder;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  DecIn;
  logic        InputValid, InputReady;
  logic [15:0] p;
  logic        pValid, pReady;
  logic        y, OutputValid, OutputReady, InitFinish;
  logic [31:0] DecLow, DecHigh, DecMid, DecX;
`ifdef ARITH_DEC_STATS_EN
  logic [31:0] BitCnt, ByteCnt;
`endif

  always #5 clk = ~clk;

  arith_decoder dut (
    .clk(clk), .rst(rst), .start(start),
    .DecIn(DecIn), .InputValid(InputValid), .InputReady(InputReady),
    .p(p), .pValid(pValid), .pReady(pReady),
    .y(y), .OutputValid(OutputValid), .OutputReady(OutputReady),
    .InitFinish(InitFinish),
    .DecLow(DecLow), .DecHigh(DecHigh), .DecMid(DecMid), .DecX(DecX)
`ifdef ARITH_DEC_STATS_EN
    , .BitCnt(BitCnt), .ByteCnt(ByteCnt)
`endif
  );

  typedef struct {
    logic        y;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] mid;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  byte_q[$];
  logic [15:0] p_q[$];

  int checks = 0;
  int errors = 0;
  int bytes_acc = 0;
  int p_acc = 0;
  bit in_stall = 0;
  bit out_rand = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // byte source
  initial begin
    bit fire;
    InputValid = 1'b0;
    DecIn = 8'h00;
    forever begin
      @(negedge clk);
      InputValid = (byte_q.size() > 0) && !in_stall;
      DecIn = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
      fire = InputValid && InputReady && !rst;
      @(posedge clk);
      if (fire) begin
        void'(byte_q.pop_front());
        bytes_acc++;
      end
    end
  end

  // probability source
  initial begin
    bit fire;
    pValid = 1'b0;
    p = 16'h0;
    forever begin
      @(negedge clk);
      pValid = (p_q.size() > 0);
      p = (p_q.size() > 0) ? p_q[0] : 16'h0;
      fire = pValid && pReady && !rst;
      @(posedge clk);
      if (fire) begin
        void'(p_q.pop_front());
        p_acc++;
      end
    end
  end

  // output monitor
  initial begin
    OutputReady = 1'b0;
    forever begin
      @(negedge clk);
      OutputReady = out_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (OutputValid && OutputReady && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual y=%b required none", y);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("y", {31'b0, y}, {31'b0, e.y});
          chk("low", DecLow, e.lo);
          chk("high", DecHigh, e.hi);
          chk("mid", DecMid, e.mid);
        end
      end
    end
  end

  task automatic reset_and_start();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bytes_acc = 0;
  endtask

  task automatic wait_idle(string name, int maxc);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && p_q.size() == 0 &&
             byte_q.size() == 0 && pReady === 1'b1) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {31'b0, pReady}, 32'd1);
  endtask

  task automatic push4(logic [7:0] b);
    repeat (4) byte_q.push_back(b);
  endtask

  task automatic gen_stream(int nbits, output int nbytes);
    logic [31:0] lo, hi, r, mid, pp;
    logic [15:0] pv;
    logic        yb;
    exp_t        e;
    lo = 32'h0;
    hi = 32'hFFFF_FFFF;
    nbytes = 0;
    for (int i = 0; i < nbits; i++) begin
      pv = 16'($urandom_range(0, 65535));
      yb = 1'($urandom_range(0, 1));
      pp = {16'h0, pv};
      r = hi - lo;
      mid = lo + (r >> 16) * pp + (((r & 32'h0000_FFFF) * pp) >> 16);
      if (yb) hi = mid;
      else    lo = mid + 32'd1;
      e.y = yb; e.lo = lo; e.hi = hi; e.mid = mid;
      exp_q.push_back(e);
      p_q.push_back(pv);
      while (hi[31:24] == lo[31:24]) begin
        byte_q.push_back(hi[31:24]);
        nbytes++;
        hi = {hi[23:0], 8'hFF};
        lo = {lo[23:0], 8'h00};
      end
    end
    for (int k = 0; k < 4; k++) begin
      byte_q.push_back(lo[31:24]);
      lo = {lo[23:0], 8'h00};
      nbytes++;
    end
  endtask

  initial begin
    int n, pa, nb;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_low", DecLow, 32'h0);
    chk("rst_high", DecHigh, 32'hFFFF_FFFF);
    chk("rst_x", DecX, 32'h0);
    chk("rst_mid", DecMid, 32'h0);
    chk("rst_sig", {27'b0, y, OutputValid, InputReady, pReady, InitFinish}, 32'h0);

    // T1
    push4(8'h00);
    reset_and_start();
    p_q.push_back(16'h8000);
    exp_q.push_back('{1'b1, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
    wait_idle("t1", 200);
    chk("t1_init", {31'b0, InitFinish}, 32'd1);
    chk("t1_bytes", bytes_acc, 32'd4);
    chk("t1_inrdy", {31'b0, InputReady}, 32'd0);

    // T2
    push4(8'hFF);
    reset_and_start();
    p_q.push_back(16'h8000);
    exp_q.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF});
    wait_idle("t2", 200);
    chk("t2_bytes", bytes_acc, 32'd4);
    chk("t2_x", DecX, 32'hFFFF_FFFF);

    // T3 with T4 underrun during the shift
    push4(8'h00);
    reset_and_start();
    n = 0;
    while (!InitFinish && n < 100) begin @(negedge clk); n++; end
    chk("t3_init", {31'b0, InitFinish}, 32'd1);
    @(posedge clk); #1;
    in_stall = 1'b1;
    byte_q.push_back(8'hAB);
    byte_q.push_back(8'hCD);
    p_q.push_back(16'h0001);
    exp_q.push_back('{1'b1, 32'h0, 32'h0000_FFFF, 32'h0000_FFFF});
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("t3_out", exp_q.size(), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_pready", {31'b0, pReady}, 32'd0);
    end
    chk("t4_high", DecHigh, 32'h0000_FFFF);
    chk("t4_x", DecX, 32'h0);
    chk("t4_inrdy", {31'b0, InputReady}, 32'd1);
    chk("t4_bytes", bytes_acc, 32'd4);
    @(posedge clk); #1;
    in_stall = 1'b0;
    wait_idle("t3", 200);
    chk("t3_bytes", bytes_acc, 32'd6);
    chk("t3_high", DecHigh, 32'hFFFF_FFFF);
    chk("t3_low", DecLow, 32'h0);
    chk("t3_x", DecX, 32'h0000_ABCD);

    // T5: reset while in S_Mid
    push4(8'h00);
    reset_and_start();
    pa = p_acc;
    p_q.push_back(16'h8000);
    n = 0;
    while (p_acc == pa && n < 200) begin @(posedge clk); #1; n++; end
    chk("t5_paccept", p_acc - pa, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_sig", {27'b0, y, OutputValid, InputReady, pReady, InitFinish}, 32'h0);
    chk("t5_low", DecLow, 32'h0);
    chk("t5_high", DecHigh, 32'hFFFF_FFFF);
    chk("t5_mid", DecMid, 32'h0);
    chk("t5_x", DecX, 32'h0);
    repeat (3) @(negedge clk);
    chk("t5_quiet", {31'b0, OutputValid}, 32'd0);
    push4(8'h00);
    reset_and_start();
    p_q.push_back(16'h8000);
    exp_q.push_back('{1'b1, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
    wait_idle("t5_t1", 200);

    // T6: round trip through the encoder model
    reset_and_start();
    gen_stream(4096, nb);
    bytes_acc = 0;
    out_rand = 1'b1;
    wait_idle("t6", 70000);
    out_rand = 1'b0;
    chk("t6_bytes", bytes_acc, nb);
    chk("t6_left", exp_q.size(), 32'd0);
`ifdef ARITH_DEC_STATS_EN
    chk("t6_bitcnt", BitCnt, 32'd4096);
    chk("t6_bytecnt", ByteCnt, nb);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
